dmem_responder: RTL and testbench

- Data-memory responder for the RV32 core's load/store path. It sits between the core's memory-request initiator and a word-organised data store.
- Accepts one request at a time over a valid/ready handshake, inserts a configurable wait-state delay, and performs byte, halfword or word loads and stores.
- Stores of byte or halfword size use read-modify-write. Load data is returned sign- or zero-extended.
- Misaligned, out-of-range and illegal-size requests are reported as errors.

---
 rtl/dmem_responder.sv | 186 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : RV32 load/store responder with wait states and byte-lane RMW.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int          c_AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] c_DEPTH    = 32'(DEPTH);
    localparam logic [3:0]  c_CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_ready;
    logic              r_we;
    logic [c_AW-1:0]   r_idx;
    logic [1:0]        r_lane;
    logic [2:0]        r_size;
    logic [31:0]       r_wdata;
    logic              r_err_pend;
    logic [3:0]        r_cnt;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [31:0]       r_rsp_rdata;
    logic [31:0]       r_mem [DEPTH];

    logic              w_size_bad;
    logic              w_misalign;
    logic              w_range_bad;
    logic              w_err;
    logic [31:0]       w_word;
    logic [31:0]       w_merged;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;

    // Request legality is judged on the live request fields at the accept edge.
    always_comb begin
        w_size_bad = 1'b0;
        w_misalign = 1'b0;
        case (req_size)
            3'b000:  w_misalign = 1'b0;
            3'b001:  w_misalign = req_addr[0];
            3'b010:  w_misalign = |req_addr[1:0];
            3'b100:  w_size_bad = req_we;
            3'b101: begin
                w_size_bad = req_we;
                w_misalign = req_addr[0];
            end
            default: w_size_bad = 1'b1;
        endcase
    end

    assign w_range_bad = ({2'b00, req_addr[31:2]} >= c_DEPTH);
    assign w_err       = w_size_bad | w_misalign | w_range_bad;

    assign w_word = r_mem[r_idx];
    assign w_byte = w_word[{r_lane, 3'b000} +: 8];
    assign w_half = w_word[{r_lane[1], 4'b0000} +: 16];

    always_comb begin
        w_merged = w_word;
        case (r_size[1:0])
            2'b00:   w_merged[{r_lane, 3'b000} +: 8]      = r_wdata[7:0];
            2'b01:   w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
            default: w_merged = r_wdata;
        endcase
    end

    always_comb begin
        case (r_size)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = w_word;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b0;
            r_we        <= 1'b0;
            r_idx       <= '0;
            r_lane      <= 2'd0;
            r_size      <= 3'd0;
            r_wdata     <= 32'd0;
            r_err_pend  <= 1'b0;
            r_cnt       <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (req_valid && r_ready) begin
                        r_ready    <= 1'b0;
                        r_we       <= req_we;
                        r_idx      <= req_addr[c_AW+1:2];
                        r_lane     <= req_addr[1:0];
                        r_size     <= req_size;
                        r_wdata    <= req_wdata;
                        r_err_pend <= w_err;
                        r_cnt      <= c_CNT_INIT;
                        if (w_err) begin
                            r_state <= S_RESP;
                        end else if (LATENCY == 0) begin
                            r_state <= S_ACCESS;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_ACCESS;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACCESS: begin
                    if (!r_we) begin
                        r_rsp_rdata <= w_load;
                    end
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_state     <= S_RESP;
                end
                default: begin
                    // Error path arrives with rsp_valid low: raise it one cycle later.
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= r_err_pend;
                    end else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= 32'd0;
                        r_ready     <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Storage is not reset; a reset forces IDLE so no write can be pending.
    always_ff @(posedge clk) begin
        if (r_state == S_ACCESS && r_we) begin
            r_mem[r_idx] <= w_merged;
        end
    end

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Randomised and directed checking of dmem_responder against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int c_DEPTH = 256;
    localparam int c_LAT   = 1;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int          n_vec;
    int          n_err;
    logic [31:0] mmem [c_DEPTH];

    dmem_responder #(.DEPTH(c_DEPTH), .LATENCY(c_LAT)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour from the architectural rules of RV32 loads/stores.
    task automatic model(input logic we, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er);
        logic [31:0] word_no;
        logic [31:0] sh;
        logic [31:0] mask;
        logic [31:0] cur;
        logic [31:0] val;
        int          nbytes;
        bit          legal;
        word_no = a >> 2;
        sh      = (a % 4) * 8;
        nbytes  = 1 << sz[1:0];
        legal   = we ? (sz <= 3'd2) : (sz <= 3'd2 || sz == 3'd4 || sz == 3'd5);
        rd      = 32'd0;
        er      = !legal || (word_no >= c_DEPTH) || ((a % nbytes) != 0);
        if (!er) begin
            cur  = mmem[word_no];
            mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
            if (we) begin
                mmem[word_no] = (cur & ~(mask << sh)) | ((wd & mask) << sh);
            end else begin
                val = (cur >> sh) & mask;
                if (sz == 3'd0 && val >= 32'h80)   val = val - 32'h100;
                if (sz == 3'd1 && val >= 32'h8000) val = val - 32'h1_0000;
                rd = val;
            end
        end
    endtask

    task automatic xact(input logic we, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) chk("ready_timeout", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_size  = sz;
        req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_size  = 3'($urandom);
        req_wdata = $urandom;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            @(posedge clk); #1;
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_data", rsp_rdata, rd);
            chk("bp_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("clr_flags", {30'd0, rsp_valid, rsp_err}, 32'd0);
        chk("clr_data", rsp_rdata, 32'd0);
    endtask

    task automatic run(input string tag, input logic we, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] wd, input int hold,
                       output logic [31:0] rd);
        logic [31:0] erd;
        logic        eer;
        logic        ger;
        int          lat;
        model(we, a, sz, wd, erd, eer);
        xact(we, a, sz, wd, hold, rd, ger, lat);
        chk({tag, "_lat"}, 32'(lat), eer ? 32'd1 : 32'(1 + c_LAT));
        chk({tag, "_data"}, rd, erd);
        chk({tag, "_err"}, {31'd0, ger}, {31'd0, eer});
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_size  = 3'd0;
        req_wdata = 32'd0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", {rsp_rdata[28:0], rsp_valid, rsp_err, busy}, 32'd0);
        chk("reset_rdy", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int w = 0; w < 32; w++) begin
            run("init", 1'b1, 32'(w * 4), 3'd2, $urandom, 0, rd);
        end

        run("sw64", 1'b1, 32'h64, 3'd2, 32'h0000_0019, 0, rd);
        run("lw64", 1'b0, 32'h64, 3'd2, 32'd0, 0, rd);
        chk("lw64_val", rd, 32'h0000_0019);

        run("sw10", 1'b1, 32'h10, 3'd2, 32'h1122_3344, 0, rd);
        run("sb12", 1'b1, 32'h12, 3'd0, 32'hFFFF_FF80, 0, rd);
        run("lw10", 1'b0, 32'h10, 3'd2, 32'd0, 0, rd);
        chk("lw10_val", rd, 32'h1180_3344);
        run("lb12", 1'b0, 32'h12, 3'd0, 32'd0, 0, rd);
        chk("lb12_val", rd, 32'hFFFF_FF80);
        run("lbu12", 1'b0, 32'h12, 3'd4, 32'd0, 0, rd);
        chk("lbu12_val", rd, 32'h0000_0080);

        run("sw20", 1'b1, 32'h20, 3'd2, 32'd0, 0, rd);
        run("sh22", 1'b1, 32'h22, 3'd1, 32'h0000_ABCD, 0, rd);
        run("lh22", 1'b0, 32'h22, 3'd1, 32'd0, 0, rd);
        chk("lh22_val", rd, 32'hFFFF_ABCD);
        run("lhu22", 1'b0, 32'h22, 3'd5, 32'd0, 0, rd);
        chk("lhu22_val", rd, 32'h0000_ABCD);
        run("lw20", 1'b0, 32'h20, 3'd2, 32'd0, 0, rd);
        chk("lw20_val", rd, 32'hABCD_0000);

        run("lw66_mis", 1'b0, 32'h66, 3'd2, 32'd0, 0, rd);
        run("sw400_oor", 1'b1, 32'h400, 3'd2, 32'h5555_AAAA, 0, rd);
        run("lw0_keep", 1'b0, 32'h0, 3'd2, 32'd0, 0, rd);
        run("size011", 1'b0, 32'h0, 3'd3, 32'd0, 0, rd);
        run("sbu_ill", 1'b1, 32'h4, 3'd4, 32'd0, 0, rd);

        run("bp_lw", 1'b0, 32'h10, 3'd2, 32'd0, 3, rd);
        chk("bp_lw_val", rd, 32'h1180_3344);

        // Store aborted by reset while still waiting for its access cycle.
        while (req_ready !== 1'b1) begin
            @(posedge clk); #1;
        end
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h08;
        req_size  = 3'd2;
        req_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        chk("rst_mid_out", {rsp_rdata[28:0], rsp_valid, rsp_err, busy}, 32'd0);
        chk("rst_mid_rdy", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run("rst_lw08", 1'b0, 32'h08, 3'd2, 32'd0, 0, rd);

        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 3) == 0) a = $urandom;
            else a = {25'd0, 5'($urandom_range(0, 31)), 2'($urandom)};
            run("rnd", 1'($urandom), a, 3'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 2), rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
